// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory sequencer: FSM state encoding,
// memory word width and the fetch anti-starvation threshold.
package mem_seq_pkg;

  localparam int MEM_WORD_W = 16;
  localparam logic [1:0] STREAK_MAX = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    I_RSP,
    D_RD_HI,
    D_RD_LO,
    D_RSP,
    D_WR_HI,
    D_WR_LO
  } mem_seq_state_t;

  // States in which a new request may be accepted.
  function automatic logic is_grant_slot(mem_seq_state_t s);
    return (s == IDLE) || (s == I_RSP) || (s == D_RSP) || (s == D_WR_LO);
  endfunction

endpackage

// File: rtl/mem_seq_prio.sv
// Grant arbitration between fetch and data requesters: data has priority
// unless data has already won STREAK_MAX times in a row against a waiting fetch.
module mem_seq_prio
  import mem_seq_pkg::*;
(
  input  logic       instr_req_i,
  input  logic       data_req_i,
  input  logic       slot_i,
  input  logic [1:0] streak_i,
  output logic       instr_gnt_o,
  output logic       data_gnt_o,
  output logic [1:0] streak_o
);

  logic fetch_turn;

  always_comb begin
    fetch_turn  = (streak_i == STREAK_MAX);
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    streak_o    = streak_i;

    if (slot_i) begin
      if (instr_req_i && (!data_req_i || fetch_turn)) begin
        instr_gnt_o = 1'b1;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
      end
    end

    if (instr_gnt_o) begin
      streak_o = 2'd0;
    end else if (data_gnt_o && instr_req_i && (streak_i != 2'd3)) begin
      streak_o = streak_i + 2'd1;
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// Single-port 16-bit memory sequencer shared by instruction fetch and data
// access; 32-bit data accesses are split into two big-endian beats.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_valid_o,
  output logic [MEM_WORD_W-1:0] instr_data_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic                  data_wide_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_valid_o,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_WORD_W-1:0] mem_wdata_o,
  input  logic [MEM_WORD_W-1:0] mem_rdata_i,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_enable_o,
  output logic                  busy_o
);

  mem_seq_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wide_q, wide_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [MEM_WORD_W-1:0] hi_q, hi_d;
  logic [1:0]            streak_q, streak_d;

  logic                  slot;
  logic [ADDR_WIDTH-1:0] addr_lo;

  // No grants while reset is held so every output reads 0 in reset.
  assign slot    = is_grant_slot(state_q) && rst_i;
  assign addr_lo = wide_q ? (addr_q + ADDR_WIDTH'(1)) : addr_q;

  mem_seq_prio u_prio (
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .slot_i      (slot),
    .streak_i    (streak_q),
    .instr_gnt_o (instr_gnt_o),
    .data_gnt_o  (data_gnt_o),
    .streak_o    (streak_d)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wide_q   <= 1'b0;
      wdata_q  <= '0;
      hi_q     <= '0;
      streak_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wide_q   <= wide_d;
      wdata_q  <= wdata_d;
      hi_q     <= hi_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wide_d        = wide_q;
    wdata_d       = wdata_q;
    hi_d          = hi_q;
    instr_valid_o = 1'b0;
    instr_data_o  = '0;
    data_valid_o  = 1'b0;
    data_rdata_o  = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_rd_en_o   = 1'b0;
    mem_wr_en_o   = 1'b0;

    unique case (state_q)
      I_RD: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = addr_q;
        state_d     = I_RSP;
      end
      I_RSP: begin
        instr_valid_o = 1'b1;
        instr_data_o  = mem_rdata_i;
      end
      D_RD_HI: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = addr_q;
        state_d     = D_RD_LO;
      end
      D_RD_LO: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = addr_lo;
        if (wide_q) hi_d = mem_rdata_i;
        state_d     = D_RSP;
      end
      D_RSP: begin
        data_valid_o = 1'b1;
        data_rdata_o = {hi_q, mem_rdata_i};
      end
      D_WR_HI: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q[31:16];
        state_d     = D_WR_LO;
      end
      D_WR_LO: begin
        mem_wr_en_o  = 1'b1;
        mem_addr_o   = addr_lo;
        mem_wdata_o  = wdata_q[15:0];
        data_valid_o = 1'b1;
      end
      default: begin
      end
    endcase

    // Grant slots either start a new access or fall back to IDLE.
    if (is_grant_slot(state_q)) begin
      state_d = IDLE;
      if (instr_gnt_o) begin
        addr_d  = instr_addr_i;
        wide_d  = 1'b0;
        wdata_d = '0;
        state_d = I_RD;
      end else if (data_gnt_o) begin
        addr_d  = data_addr_i;
        wide_d  = data_wide_i;
        wdata_d = data_wdata_i;
        if (data_we_i) begin
          state_d = data_wide_i ? D_WR_HI : D_WR_LO;
        end else if (data_wide_i) begin
          state_d = D_RD_HI;
        end else begin
          state_d = D_RD_LO;
          hi_d    = '0;
        end
      end
    end
  end

  assign mem_enable_o = mem_rd_en_o | mem_wr_en_o;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequences all accesses to the single-port, 16-bit-wide external memory and shares it between the fetch stage (16-bit instruction reads) and the execute/mem stage (16- or 32-bit data reads and writes). It sits between the pipeline stages and the memory pins. It arbitrates with data priority plus an anti-starvation rule, splits 32-bit data accesses into two 16-bit beats, and returns results through one-cycle valid pulses.

## Interface
- ADDR_WIDTH, 8, memory word-address width.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_req_i  in  1  fetch request; held with address until granted.
- instr_addr_i  in  ADDR_WIDTH  fetch word address.
- instr_gnt_o  out  1  fetch accepted this cycle (combinational).
- instr_valid_o  out  1  one-cycle pulse: instr_data_o valid.
- instr_data_o  out  16  fetched instruction.
- data_req_i  in  1  data request; held with operands until granted.
- data_we_i  in  1  1 = write, 0 = read.
- data_wide_i  in  1  1 = 32-bit (two beats), 0 = 16-bit.
- data_addr_i  in  ADDR_WIDTH  data word address (high half for wide).
- data_wdata_i  in  32  write data; narrow writes use [15:0].
- data_gnt_o  out  1  data accepted this cycle (combinational).
- data_valid_o  out  1  one-cycle pulse: read data valid / write complete.
- data_rdata_o  out  32  read data; narrow reads are zero-extended.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  16  memory write data.
- mem_rdata_i  in  16  memory read data, valid the cycle after mem_rd_en_o.
- mem_rd_en_o  out  1  read strobe.
- mem_wr_en_o  out  1  write strobe.
- mem_enable_o  out  1  mem_rd_en_o | mem_wr_en_o.
- busy_o  out  1  state != IDLE.

## Operation
- FSM states: IDLE, I_RD, I_RSP, D_RD_HI, D_RD_LO, D_RSP, D_WR_HI, D_WR_LO.
- Grant slots: IDLE, I_RSP, D_RSP and D_WR_LO. A grant is issued only in a slot, and at most one grant per cycle.
- On a grant, the address, we, wide and wdata are latched and the next state is chosen by request type:
  - fetch: I_RD.
  - wide read: D_RD_HI.
  - narrow read: D_RD_LO, with the high register cleared.
  - wide write: D_WR_HI.
  - narrow write: D_WR_LO.
- With no grant in a slot, the FSM goes to IDLE.
- Priority: data wins, except that when streak == 2 and both requests are pending, fetch wins.
- streak (2-bit, saturating):
  - increments on a data grant while instr_req_i = 1.
  - clears on a fetch grant.
- I_RD: mem_rd_en_o = 1 at the latched address; the FSM then moves to I_RSP.
- I_RSP: instr_valid_o = 1 and instr_data_o = mem_rdata_i.
- D_RD_HI: read at addr.
- D_RD_LO: read at addr + 1 for wide, addr for narrow. For wide, mem_rdata_i is captured into the high register.
- D_RSP: data_valid_o = 1 and data_rdata_o = {hi_reg, mem_rdata_i}.
- D_WR_HI: write data_wdata_i[31:16] at addr.
- D_WR_LO: write [15:0] at addr + 1 for wide, addr for narrow. data_valid_o = 1 in this same cycle.
- Endianness is big-endian: the high half is at the lower address.
- addr + 1 wraps modulo 2^ADDR_WIDTH, so 255 is followed by 0.
- mem_addr_o and mem_wdata_o are 0 in any cycle without a strobe.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and streak to 0.
- Fetch: grant at cycle C, strobe at C+1, valid at C+2.
- Wide read: strobes at C+1 and C+2, valid at C+3.
- Narrow read: strobe at C+1, valid at C+2.
- Wide write: strobes at C+1 and C+2, valid at C+2.
- Narrow write: strobe and valid at C+1.
- Back-to-back throughput: a fetch every 2 cycles, a wide write every 2 cycles.
- A requester may drop req the cycle after gnt. Operands are not sampled after gnt.
- Simultaneous valid and gnt in I_RSP or D_RSP is legal and expected.
- Reset asserted mid-access: the access aborts with no valid pulse and no further strobes. The requester re-issues it.

## Structure
- Package mem_seq_pkg holds the state enum (mem_seq_state_t), MEM_WORD_W = 16, and the STREAK_MAX = 2 constant.
- One sub-module, mem_seq_prio, is natural: it takes the requests, slot flag and streak, and produces the grants and the next streak.
- Everything else (FSM, latched request, hi_reg) lives in mem_sequencer.

## Test plan
- Fetch at addr 0x10, memory returns 0xBEEF: mem_rd_en_o at C+1 with addr 0x10, then instr_valid_o with 0xBEEF at C+2.
- Wide read at 0xFF, memory returns 0x1234 then 0x5678: strobes at addresses 0xFF then 0x00, then data_rdata_o = 0x12345678 with valid at C+3.
- Wide write of 0xCAFEF00D at 0x20: mem_wdata_o is 0xCAFE at 0x20, then 0xF00D at 0x21 with data_valid_o.
- Both requests held continuously with wide reads:
  - grant order is D, D, I, D, D, I.
  - fetch is never starved.
- Narrow read at 0x05 returning 0x00AB: data_rdata_o = 0x000000AB, with exactly one strobe.
- rst_i low during D_RD_LO: all outputs are 0 asynchronously, there is no valid pulse, and after release busy_o = 0.
